// File: rtl/ysyx_22041071_axi_rd_arbiter_pkg.sv
// Shared definitions for the two-master AXI read arbiter: FSM states,
// owner IDs carried on the AR channel, and AXI beat size codes.
package ysyx_22041071_axi_rd_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    // Owner ID doubles as axi_ar_id and as the round-robin history value.
    localparam logic OWNER_IF  = 1'b0;
    localparam logic OWNER_MEM = 1'b1;

    localparam logic [1:0] SIZE_B = 2'b00;
    localparam logic [1:0] SIZE_H = 2'b01;
    localparam logic [1:0] SIZE_W = 2'b10;
    localparam logic [1:0] SIZE_D = 2'b11;

endpackage

// File: rtl/ysyx_22041071_axi_rd_arbiter.sv
// Round-robin arbiter sharing one AXI read channel between instruction fetch
// and the LSU, with a single outstanding burst and beat-count checking.
module ysyx_22041071_axi_rd_arbiter
    import ysyx_22041071_axi_rd_arbiter_pkg::*;
#(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64,
    parameter int LEN_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_ar_valid,
    output logic              if_ar_ready,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic [LEN_W-1:0]  if_len,
    input  logic [1:0]        if_size,
    output logic              if_r_valid,
    output logic [DATA_W-1:0] if_r_data,
    output logic              if_r_last,
    input  logic              mem_ar_valid,
    output logic              mem_ar_ready,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [LEN_W-1:0]  mem_len,
    input  logic [1:0]        mem_size,
    output logic              mem_r_valid,
    output logic [DATA_W-1:0] mem_r_data,
    output logic              mem_r_last,
    output logic              axi_ar_valid,
    input  logic              axi_ar_ready,
    output logic [ADDR_W-1:0] axi_ar_addr,
    output logic [LEN_W-1:0]  axi_ar_len,
    output logic [1:0]        axi_ar_size,
    output logic              axi_ar_id,
    input  logic              axi_r_valid,
    output logic              axi_r_ready,
    input  logic [DATA_W-1:0] axi_r_data,
    input  logic              axi_r_last,
    output logic              len_err
);

    state_t              state;
    logic                owner;
    logic                last_grant;
    logic [ADDR_W-1:0]   addr_q;
    logic [LEN_W-1:0]    len_q;
    logic [1:0]          size_q;
    logic [LEN_W:0]      beat_cnt;
    logic                grant_if;
    logic                grant_mem;
    logic                in_idle;
    logic                in_data;

    // Tie goes to whichever requester did not win the previous burst.
    assign grant_if  = if_ar_valid  && (!mem_ar_valid || (last_grant == OWNER_MEM));
    assign grant_mem = mem_ar_valid && (!if_ar_valid  || (last_grant == OWNER_IF));

    assign in_idle = reset && (state == ST_IDLE);
    assign in_data = reset && (state == ST_DATA);

    assign if_ar_ready  = in_idle && grant_if;
    assign mem_ar_ready = in_idle && grant_mem;

    assign axi_ar_addr = addr_q;
    assign axi_ar_len  = len_q;
    assign axi_ar_size = size_q;
    assign axi_ar_id   = owner;

    // Read beats are only visible to the owner; everything else sees zeros.
    assign if_r_valid  = in_data && (owner == OWNER_IF)  && axi_r_valid;
    assign if_r_data   = (in_data && (owner == OWNER_IF))  ? axi_r_data : '0;
    assign if_r_last   = in_data && (owner == OWNER_IF)  && axi_r_last;
    assign mem_r_valid = in_data && (owner == OWNER_MEM) && axi_r_valid;
    assign mem_r_data  = (in_data && (owner == OWNER_MEM)) ? axi_r_data : '0;
    assign mem_r_last  = in_data && (owner == OWNER_MEM) && axi_r_last;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= ST_IDLE;
            owner        <= OWNER_IF;
            last_grant   <= OWNER_MEM;
            addr_q       <= '0;
            len_q        <= '0;
            size_q       <= '0;
            beat_cnt     <= '0;
            axi_ar_valid <= 1'b0;
            axi_r_ready  <= 1'b0;
            len_err      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (grant_if || grant_mem) begin
                        addr_q       <= grant_if ? if_addr : mem_addr;
                        len_q        <= grant_if ? if_len  : mem_len;
                        size_q       <= grant_if ? if_size : mem_size;
                        owner        <= grant_if ? OWNER_IF : OWNER_MEM;
                        beat_cnt     <= '0;
                        axi_ar_valid <= 1'b1;
                        state        <= ST_ADDR;
                    end
                end
                ST_ADDR: begin
                    if (axi_ar_ready) begin
                        axi_ar_valid <= 1'b0;
                        axi_r_ready  <= 1'b1;
                        state        <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (axi_r_valid) begin
                        beat_cnt <= beat_cnt + 1'b1;
                        // The slave's r_last is authoritative for ending the burst;
                        // disagreement with the requested length is only flagged.
                        if (axi_r_last) begin
                            if (beat_cnt != {1'b0, len_q}) begin
                                len_err <= 1'b1;
                            end
                            axi_r_ready <= 1'b0;
                            last_grant  <= owner;
                            state       <= ST_IDLE;
                        end else if (beat_cnt >= {1'b0, len_q}) begin
                            len_err <= 1'b1;
                        end
                    end
                end
                default: begin
                    state        <= ST_IDLE;
                    axi_ar_valid <= 1'b0;
                    axi_r_ready  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_22041071_axi_rd_arbiter.sv
// Directed bench for the AXI read arbiter: single requests, round-robin ties,
// AR back-pressure, short bursts and reset in the middle of a burst.
module tb_ysyx_22041071_axi_rd_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_ar_valid, mem_ar_valid;
    logic        if_ar_ready, mem_ar_ready;
    logic [63:0] if_addr, mem_addr;
    logic [7:0]  if_len, mem_len;
    logic [1:0]  if_size, mem_size;
    logic        if_r_valid, mem_r_valid;
    logic [63:0] if_r_data, mem_r_data;
    logic        if_r_last, mem_r_last;
    logic        axi_ar_valid, axi_ar_ready;
    logic [63:0] axi_ar_addr;
    logic [7:0]  axi_ar_len;
    logic [1:0]  axi_ar_size;
    logic        axi_ar_id;
    logic        axi_r_valid, axi_r_ready;
    logic [63:0] axi_r_data;
    logic        axi_r_last;
    logic        len_err;

    int checks   = 0;
    int failures = 0;

    ysyx_22041071_axi_rd_arbiter #(
        .ADDR_W(64),
        .DATA_W(64),
        .LEN_W (8)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .if_ar_valid (if_ar_valid),
        .if_ar_ready (if_ar_ready),
        .if_addr     (if_addr),
        .if_len      (if_len),
        .if_size     (if_size),
        .if_r_valid  (if_r_valid),
        .if_r_data   (if_r_data),
        .if_r_last   (if_r_last),
        .mem_ar_valid(mem_ar_valid),
        .mem_ar_ready(mem_ar_ready),
        .mem_addr    (mem_addr),
        .mem_len     (mem_len),
        .mem_size    (mem_size),
        .mem_r_valid (mem_r_valid),
        .mem_r_data  (mem_r_data),
        .mem_r_last  (mem_r_last),
        .axi_ar_valid(axi_ar_valid),
        .axi_ar_ready(axi_ar_ready),
        .axi_ar_addr (axi_ar_addr),
        .axi_ar_len  (axi_ar_len),
        .axi_ar_size (axi_ar_size),
        .axi_ar_id   (axi_ar_id),
        .axi_r_valid (axi_r_valid),
        .axi_r_ready (axi_r_ready),
        .axi_r_data  (axi_r_data),
        .axi_r_last  (axi_r_last),
        .len_err     (len_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic iv, input logic mv,
                                 input logic [63:0] ia, input logic [63:0] ma,
                                 input logic [7:0] il, input logic [7:0] ml);
        if_ar_valid  = iv;
        mem_ar_valid = mv;
        if_addr      = ia;
        mem_addr     = ma;
        if_len       = il;
        mem_len      = ml;
        if_size      = 2'b11;
        mem_size     = 2'b10;
        #1;
    endtask

    task automatic acceptAddr();
        axi_ar_ready = 1'b1;
        tick();
        axi_ar_ready = 1'b0;
    endtask

    task automatic driveBeat(input logic [63:0] data, input logic last);
        axi_r_valid = 1'b1;
        axi_r_data  = data;
        axi_r_last  = last;
        #1;
    endtask

    task automatic clearBeat();
        axi_r_valid = 1'b0;
        axi_r_data  = '0;
        axi_r_last  = 1'b0;
    endtask

    initial begin
        reset        = 1'b0;
        axi_ar_ready = 1'b0;
        clearBeat();
        applyStimulus(0, 0, 0, 0, 0, 0);
        #12;
        checkOutput("rst_ar_valid", axi_ar_valid, 0);
        checkOutput("rst_r_ready",  axi_r_ready,  0);
        checkOutput("rst_len_err",  len_err,      0);
        checkOutput("rst_ar_addr",  axi_ar_addr,  0);
        @(negedge clk);
        reset = 1'b1;
        tick();

        // Single IF request, one-beat burst
        applyStimulus(1, 0, 64'h8000_0000, 0, 0, 0);
        checkOutput("t1_if_ar_ready",  if_ar_ready,  1);
        checkOutput("t1_mem_ar_ready", mem_ar_ready, 0);
        checkOutput("t1_ar_valid_0",   axi_ar_valid, 0);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("t1_ar_valid_1", axi_ar_valid, 1);
        checkOutput("t1_ar_addr",    axi_ar_addr,  64'h8000_0000);
        checkOutput("t1_ar_id",      axi_ar_id,    0);
        checkOutput("t1_ar_len",     axi_ar_len,   0);
        checkOutput("t1_ar_size",    axi_ar_size,  2'b11);
        checkOutput("t1_ready_busy", if_ar_ready,  0);
        acceptAddr();
        checkOutput("t1_r_ready",    axi_r_ready,  1);
        checkOutput("t1_ar_valid_d", axi_ar_valid, 0);
        driveBeat(64'h1234, 1);
        checkOutput("t1_if_r_valid",  if_r_valid,  1);
        checkOutput("t1_if_r_data",   if_r_data,   64'h1234);
        checkOutput("t1_if_r_last",   if_r_last,   1);
        checkOutput("t1_mem_r_valid", mem_r_valid, 0);
        tick();
        clearBeat();
        checkOutput("t1_r_ready_end", axi_r_ready, 0);

        // Round-robin ties starting from a fresh reset
        reset = 1'b0;
        tick();
        reset = 1'b1;
        #1;
        applyStimulus(1, 1, 64'h100, 64'h200, 0, 0);
        checkOutput("t2a_if_ready",  if_ar_ready,  1);
        checkOutput("t2a_mem_ready", mem_ar_ready, 0);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("t2a_id",   axi_ar_id,   0);
        checkOutput("t2a_addr", axi_ar_addr, 64'h100);
        acceptAddr();
        driveBeat(64'h1, 1);
        checkOutput("t2a_if_r_valid", if_r_valid, 1);
        tick();
        clearBeat();
        applyStimulus(1, 1, 64'h100, 64'h200, 0, 0);
        checkOutput("t2b_if_ready",  if_ar_ready,  0);
        checkOutput("t2b_mem_ready", mem_ar_ready, 1);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("t2b_id",   axi_ar_id,   1);
        checkOutput("t2b_addr", axi_ar_addr, 64'h200);
        acceptAddr();
        driveBeat(64'h2, 1);
        checkOutput("t2b_mem_r_valid", mem_r_valid, 1);
        checkOutput("t2b_mem_r_data",  mem_r_data,  64'h2);
        checkOutput("t2b_if_r_valid",  if_r_valid,  0);
        tick();
        clearBeat();
        applyStimulus(1, 1, 64'h100, 64'h200, 0, 0);
        checkOutput("t2c_if_ready",  if_ar_ready,  1);
        checkOutput("t2c_mem_ready", mem_ar_ready, 0);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("t2c_id", axi_ar_id, 0);
        acceptAddr();
        driveBeat(64'h3, 1);
        tick();
        clearBeat();

        // MEM burst of 4 with AR back-pressure
        applyStimulus(0, 1, 0, 64'h8000_1000, 0, 3);
        checkOutput("t3_mem_ready", mem_ar_ready, 1);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            checkOutput("t3_ar_valid_hold", axi_ar_valid, 1);
            checkOutput("t3_ar_addr_hold",  axi_ar_addr,  64'h8000_1000);
            tick();
        end
        checkOutput("t3_ar_len", axi_ar_len, 3);
        acceptAddr();
        for (int i = 0; i < 4; i++) begin
            driveBeat(64'hA0 + 64'(i), (i == 3));
            checkOutput("t3_mem_r_valid", mem_r_valid, 1);
            checkOutput("t3_mem_r_data",  mem_r_data,  64'hA0 + 64'(i));
            checkOutput("t3_mem_r_last",  mem_r_last,  (i == 3));
            checkOutput("t3_if_r_valid",  if_r_valid,  0);
            tick();
            clearBeat();
        end
        checkOutput("t3_len_err",  len_err,     0);
        checkOutput("t3_r_ready",  axi_r_ready, 0);

        // MEM burst of 4 terminated early by the slave
        applyStimulus(0, 1, 0, 64'h8000_2000, 0, 3);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0);
        acceptAddr();
        driveBeat(64'hB0, 0);
        checkOutput("t4_len_err_0", len_err, 0);
        tick();
        driveBeat(64'hB1, 1);
        tick();
        clearBeat();
        checkOutput("t4_len_err_1", len_err,     1);
        checkOutput("t4_r_ready",   axi_r_ready, 0);
        applyStimulus(1, 0, 64'h40, 0, 0, 0);
        checkOutput("t4_idle_ready", if_ar_ready, 1);
        applyStimulus(0, 0, 0, 0, 0, 0);

        // Reset during beat 1 of a 4-beat IF burst
        applyStimulus(1, 0, 64'h8000_3000, 0, 3, 0);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0);
        acceptAddr();
        driveBeat(64'hC0, 0);
        tick();
        driveBeat(64'hC1, 0);
        checkOutput("t5_beat1_valid", if_r_valid, 1);
        reset = 1'b0;
        #1;
        checkOutput("t5_rst_r_valid",  if_r_valid,   0);
        checkOutput("t5_rst_r_data",   if_r_data,    0);
        checkOutput("t5_rst_r_ready",  axi_r_ready,  0);
        checkOutput("t5_rst_ar_valid", axi_ar_valid, 0);
        checkOutput("t5_rst_len_err",  len_err,      0);
        checkOutput("t5_rst_ar_addr",  axi_ar_addr,  0);
        applyStimulus(1, 0, 64'h8000_4000, 0, 0, 0);
        checkOutput("t5_rst_ar_ready", if_ar_ready, 0);
        clearBeat();
        tick();
        reset = 1'b1;
        #1;
        checkOutput("t5_post_ready", if_ar_ready, 1);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("t5_post_ar_valid", axi_ar_valid, 1);
        checkOutput("t5_post_addr",     axi_ar_addr,  64'h8000_4000);
        acceptAddr();
        driveBeat(64'h55, 1);
        checkOutput("t5_post_r_valid", if_r_valid, 1);
        checkOutput("t5_post_r_data",  if_r_data,  64'h55);
        tick();
        clearBeat();
        checkOutput("t5_post_len_err", len_err, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ysyx_22041071_axi_rd_arbiter.md
YSYX_22041071_AXI_RD_ARBITER -- requirements
Module: ysyx_22041071_axi_rd_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 64, address width (ysyx_22041071_ADDR_BUS).
REQ-002 SHALL have parameter DATA_W, default 64, read data width.
REQ-003 SHALL have parameter LEN_W, default 8, burst length width (ysyx_22041071_AXI_LEN_WIDTH).
REQ-004 SHALL have port clk  in  1  sole clock, rising edge.
REQ-005 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-006 SHALL have ports if_ar_valid / mem_ar_valid  in  1  fetch / LSU read request.
REQ-007 SHALL have ports if_ar_ready / mem_ar_ready  out  1  request accepted.
REQ-008 SHALL have ports if_addr / mem_addr  in  ADDR_W  request address.
REQ-009 SHALL have ports if_len / mem_len  in  LEN_W  beats minus one.
REQ-010 SHALL have ports if_size / mem_size  in  2  beat size code.
REQ-011 SHALL have ports if_r_valid / mem_r_valid  out  1  routed read beat valid.
REQ-012 SHALL have ports if_r_data / mem_r_data  out  DATA_W  routed read data.
REQ-013 SHALL have ports if_r_last / mem_r_last  out  1  routed last beat.
REQ-014 SHALL have ports axi_ar_valid out 1; axi_ar_ready in 1; axi_ar_addr out ADDR_W; axi_ar_len out LEN_W; axi_ar_size out 2; axi_ar_id out 1 (0=IF, 1=MEM).
REQ-015 SHALL have ports axi_r_valid in 1; axi_r_ready out 1; axi_r_data in DATA_W; axi_r_last in 1.
REQ-016 SHALL have port len_err  out  1  sticky: beat count disagreed with len.

Function
REQ-017 SHALL implement FSM IDLE -> ADDR -> DATA -> IDLE; one outstanding transaction max.
REQ-018 IDLE, one requester valid: that requester wins.
REQ-019 IDLE, both valid: winner is the one not granted last (round-robin via last_grant register).
REQ-020 In IDLE, winner's ar_ready SHALL be 1 combinationally in the same cycle; loser's ar_ready 0; both 0 in ADDR/DATA.
REQ-021 On acceptance, addr/len/size/owner SHALL be registered; state -> ADDR next cycle (axi_ar_valid earliest 1 cycle after acceptance).
REQ-022 ADDR: axi_ar_valid=1, fields stable from registers until axi_ar_ready=1; then -> DATA.
REQ-023 DATA: axi_r_ready=1; axi_r_valid/data/last routed to owner only; non-owner r_valid=0.
REQ-024 DATA: beat counter increments per accepted beat; on axi_r_valid & axi_r_last -> IDLE, last_grant <= owner.
REQ-025 Last beat with count != len, or count > len without r_last, SHALL set len_err; FSM still exits only on r_last.
REQ-026 axi_r_ready=0 and all requester r_valid=0 outside DATA; stray axi_r_valid ignored.
REQ-027 New request may be accepted in the IDLE cycle directly after r_last (no extra bubble).

Reset
REQ-028 reset=0 SHALL asynchronously force: state IDLE, axi_ar_valid 0, axi_r_ready 0, all ar_ready/r_valid 0, counter 0, len_err 0, last_grant MEM (first tie goes to IF); registered addr/len/size 0.
REQ-029 Reset mid-ADDR/DATA SHALL abandon the transaction without a completion beat to the owner.

Structure
REQ-030 State encoding, owner IDs and size codes SHALL live in the shared define file beside ysyx_22041071_SIZE_D.
REQ-031 Single module; no sub-module required.

Verification
REQ-032 IF only, addr 0x80000000 len 0; ar_ready same cycle; axi_ar_valid next cycle, id 0; one beat 0x1234 with last -> if_r_valid=1, data 0x1234, mem_r_valid=0.
REQ-033 Both valid after reset -> IF granted; next tie -> MEM; next tie -> IF.
REQ-034 MEM len 3, axi_ar_ready held 0 for 5 cycles -> axi_ar_addr stable all 5; 4 beats routed to MEM, last on 4th; len_err stays 0.
REQ-035 MEM len 3, r_last on beat 2 -> len_err=1, FSM IDLE next cycle.
REQ-036 Reset asserted during DATA beat 1 of 4 -> all outputs zero immediately; post-reset IF request served normally.
